// File: rtl/apb_fifo_periph.sv
// APB slave exposing a word FIFO through STATUS/PUSH/POP/CTRL registers at PADDR[3:2].
// Latency: action on the edge ending access cycle 1, PREADY one cycle later (3 cycles/transfer); never stalls beyond that.
module apb_fifo_periph #(
    parameter int DEPTH = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic [31:0] PWDATA,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        fifo_empty,
    output logic        fifo_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {IDLE, ACK} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic [31:0]     prdata_q, prdata_d;
    logic [31:0]     mem [DEPTH];
    logic            mem_we;
    logic [PW-1:0]   count;
    logic [31:0]     status;
    logic            fire;

    // Upper address bits are decoded by the master.
    logic unused_addr;
    assign unused_addr = ^{PADDR[31:4], PADDR[1:0]};

    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == PW'(DEPTH));
    assign status     = {16'h0, 8'(count), 4'h0, udf_q, ovf_q, fifo_full, fifo_empty};
    assign PREADY     = (state_q == ACK);
    assign PRDATA     = prdata_q;
    // PREADY is high for the whole ACK cycle, so a held select cannot re-trigger there.
    assign fire       = PSEL & PENABLE & ~PREADY;

    always_comb begin
        state_d  = IDLE;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        prdata_d = '0;
        mem_we   = 1'b0;
        if (state_q == IDLE && fire) begin
            state_d = ACK;
            case (PADDR[3:2])
                2'd0: if (!PWRITE) prdata_d = status;
                2'd1: if (PWRITE) begin
                    if (fifo_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                end
                2'd2: if (!PWRITE) begin
                    if (fifo_empty) begin
                        udf_d = 1'b1;
                    end else begin
                        prdata_d = mem[rd_ptr_q[AW-1:0]];
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                end
                default: if (PWRITE) begin
                    if (PWDATA[0]) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                    end
                    if (PWDATA[1]) begin
                        ovf_d = 1'b0;
                        udf_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            prdata_q <= prdata_d;
        end
    end

    // Storage has no reset; pointers alone define validity.
    always_ff @(posedge PCLK) begin
        if (mem_we) mem[wr_ptr_q[AW-1:0]] <= PWDATA;
    end
endmodule

// File: tb/tb_apb_fifo_periph.sv
// Bench for apb_fifo_periph: directed scenarios plus random traffic against a queue-based model.
module tb_apb_fifo_periph;
    localparam int DEPTH = 8;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic [31:0] PADDR = '0;
    logic        PWRITE = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic        PSEL = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        fifo_empty;
    logic        fifo_full;

    apb_fifo_periph #(.DEPTH(DEPTH)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PWDATA(PWDATA), .PSEL(PSEL), .PRDATA(PRDATA),
        .PREADY(PREADY), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad = 0;

    logic [31:0] q[$];
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = (q.size() == 0);
        s[1] = (q.size() == DEPTH);
        s[2] = m_ovf;
        s[3] = m_udf;
        s[15:8] = 8'(q.size());
        return s;
    endfunction

    // Reference behaviour of one register access.
    task automatic model_xfer(input bit wr, input logic [1:0] a, input logic [31:0] d,
                              output logic [31:0] exp);
        exp = '0;
        case (a)
            2'd0: if (!wr) exp = m_status();
            2'd1: if (wr) begin
                if (q.size() == DEPTH) m_ovf = 1'b1;
                else q.push_back(d);
            end
            2'd2: if (!wr) begin
                if (q.size() == 0) m_udf = 1'b1;
                else exp = q.pop_front();
            end
            default: if (wr) begin
                if (d[0]) q.delete();
                if (d[1]) begin
                    m_ovf = 1'b0;
                    m_udf = 1'b0;
                end
            end
        endcase
    endtask

    // One full APB transfer; checks latency, data, flags and single-cycle PREADY.
    task automatic op(input string tag, input bit wr, input logic [1:0] a, input logic [31:0] d,
                      output logic [31:0] rdata);
        logic [31:0] exp;
        int lat;
        bit seen;
        model_xfer(wr, a, d, exp);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PWDATA = d;
        PADDR = ($urandom & 32'hFFFF_FFF0) | {28'h0, a, 2'b00};
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge PCLK);
            lat++;
            if (PREADY === 1'b1) seen = 1'b1;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        rdata = PRDATA;
        chk({tag, "_rdata"}, PRDATA, exp);
        chk({tag, "_empty"}, {31'h0, fifo_empty}, {31'h0, q.size() == 0});
        chk({tag, "_full"}, {31'h0, fifo_full}, {31'h0, q.size() == DEPTH});
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk({tag, "_rdy_pulse"}, {31'h0, PREADY}, 32'h0);
        chk({tag, "_rdata_idle"}, PRDATA, 32'h0);
    endtask

    logic [31:0] rd;

    initial begin
        repeat (3) @(negedge PCLK);
        chk("rst_ready", {31'h0, PREADY}, 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_empty", {31'h0, fifo_empty}, 32'h1);
        chk("rst_full", {31'h0, fifo_full}, 32'h0);
        PRESET = 1'b1;

        op("st0", 1'b0, 2'd0, 32'h0, rd);
        chk("st0_const", rd, 32'h0000_0001);

        for (int i = 10; i <= 12; i++) op("push3", 1'b1, 2'd1, 32'(i), rd);
        op("st3", 1'b0, 2'd0, 32'h0, rd);
        chk("st3_const", rd, 32'h0000_0300);
        for (int i = 10; i <= 12; i++) begin
            op("pop3", 1'b0, 2'd2, 32'h0, rd);
            chk("pop3_const", rd, 32'(i));
        end
        op("st_e", 1'b0, 2'd0, 32'h0, rd);
        chk("st_e_const", rd, 32'h0000_0001);

        for (int i = 1; i <= 9; i++) op("pushf", 1'b1, 2'd1, 32'(i), rd);
        op("st_full", 1'b0, 2'd0, 32'h0, rd);
        chk("st_full_const", rd, 32'h0000_0806);
        for (int i = 1; i <= 8; i++) begin
            op("popf", 1'b0, 2'd2, 32'h0, rd);
            chk("popf_const", rd, 32'(i));
        end
        op("pop_empty", 1'b0, 2'd2, 32'h0, rd);
        chk("pop_empty_const", rd, 32'h0);
        op("st_udf", 1'b0, 2'd0, 32'h0, rd);
        chk("st_udf_bit3", {31'h0, rd[3]}, 32'h1);
        op("ctrl_clr", 1'b1, 2'd3, 32'h2, rd);
        op("st_clr", 1'b0, 2'd0, 32'h0, rd);
        chk("st_clr_const", rd, 32'h0000_0001);
        for (int i = 0; i < 3; i++) op("pushfl", 1'b1, 2'd1, 32'hA0 + 32'(i), rd);
        op("ctrl_flush", 1'b1, 2'd3, 32'h1, rd);
        op("st_flush", 1'b0, 2'd0, 32'h0, rd);
        chk("st_flush_cnt", {24'h0, rd[15:8]}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            op("wrap_push", 1'b1, 2'd1, 32'(100 + i), rd);
            op("wrap_pop", 1'b0, 2'd2, 32'h0, rd);
            chk("wrap_val", rd, 32'(100 + i));
        end
        op("wrap_st", 1'b0, 2'd0, 32'h0, rd);
        chk("wrap_st_const", rd, 32'h0000_0001);

        // Select dropped after setup: nothing may happen.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h77;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b1;
        repeat (2) begin
            @(negedge PCLK);
            chk("abort_rdy", {31'h0, PREADY}, 32'h0);
        end
        PENABLE = 1'b0;
        op("abort_st", 1'b0, 2'd0, 32'h0, rd);

        // Reset during access cycle 1 of a push.
        op("pre_rst_push", 1'b1, 2'd1, 32'h33, rd);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h55;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        chk("arst_rdy", {31'h0, PREADY}, 32'h0);
        chk("arst_empty", {31'h0, fifo_empty}, 32'h1);
        repeat (2) begin
            @(negedge PCLK);
            chk("arst_hold_rdy", {31'h0, PREADY}, 32'h0);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b1;
        op("arst_st", 1'b0, 2'd0, 32'h0, rd);
        chk("arst_st_const", rd, 32'h0000_0001);

        for (int n = 0; n < 250; n++) begin
            int r;
            logic [31:0] d;
            r = $urandom_range(0, 19);
            d = $urandom;
            if (r < 7)       op("rnd_push", 1'b1, 2'd1, d, rd);
            else if (r < 13) op("rnd_pop", 1'b0, 2'd2, d, rd);
            else if (r < 16) op("rnd_st", 1'b0, 2'd0, d, rd);
            else if (r < 17) op("rnd_ctrl", 1'b1, 2'd3, d & 32'h3, rd);
            else             op("rnd_odd", 1'(r[0]), 2'(r), d & 32'hFFFF_FFFC, rd);
        end
        op("final_st", 1'b0, 2'd0, 32'h0, rd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
